// File: rtl/osc_pkg.sv
// osc_pkg: 16Q.16N oscillator constants shared by the increment calculator and the phase accumulator.
package osc_pkg;
    localparam int          PH_W         = 32;
    localparam int          SYN_CLK_RATE = 1000000;
    localparam logic [31:0] PIX2         = 32'h0006_487E;
    localparam logic [31:0] PI           = 32'h0003_243F;
    localparam logic [31:0] HALFPI       = 32'h0001_921F;
    localparam logic [15:0] INV_HALFPI   = 16'hA2FA;

    typedef logic [PH_W-1:0] phase_t;

    // Quarter-wave table entry, sampled at bin centres; evaluated only at elaboration.
    function automatic logic [15:0] quarter_sine(input int a, input int aw);
        real x, t, s;
        x = (real'(a) + 0.5) * 3.141592653589793 / real'(2 << aw);
        t = x;
        s = 0.0;
        for (int k = 1; k < 12; k++) begin
            s = s + t;
            t = -t * x * x / real'((2 * k) * (2 * k + 1));
        end
        return 16'(int'(32767.0 * s));
    endfunction
endpackage

// File: rtl/sine_quarter_rom.sv
// sine_quarter_rom: registered-read quarter-wave sine table, 2**LUT_AW entries of 0..32767.
module sine_quarter_rom
    import osc_pkg::*;
#(
    parameter int LUT_AW = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ce,
    input  logic [LUT_AW-1:0] addr,
    output logic [15:0]       data
);
    logic [15:0] lut [2**LUT_AW];

    for (genvar i = 0; i < 2**LUT_AW; i++) begin : g_rom
        localparam logic [15:0] V = quarter_sine(i, LUT_AW);
        assign lut[i] = V;
    end

    always_ff @(posedge clk) begin
        if (rst)
            data <= '0;
        else if (ce)
            data <= lut[addr];
    end
endmodule

// File: rtl/sinusoid_phase_accumulator.sv
// sinusoid_phase_accumulator: phase accumulator modulo 2*pi feeding a quarter-wave sine lookup.
// Pipeline: accumulate -> quadrant fold -> scale/mirror -> ROM read -> sign.
module sinusoid_phase_accumulator
    import osc_pkg::*;
#(
    parameter int LUT_AW = 8
) (
    input  logic               Sys_clk,
    input  logic               Osc_rst,
    input  logic               Osc_ce,
    input  logic               Upd_tick,
    input  logic               Phase_sync,
    input  logic [31:0]        Sin_inc,
    output logic [31:0]        Phase,
    output logic               Wrap,
    output logic signed [15:0] Sample,
    output logic               Sample_vld
);
    logic [31:0]       inc_eff;
    logic [32:0]       sum;
    logic              wrap_c;
    logic              sync_flag;
    logic              sync_now;
    logic [1:0]        q_c, q2, q3, q4;
    logic [31:0]       base_c;
    logic [17:0]       off2;
    logic [33:0]       prod, scaled;
    logic [LUT_AW-1:0] a_sat, addr3;
    logic              v1, v2, v3, v4;
    logic [15:0]       rom_q;

    always_comb begin
        inc_eff  = Sin_inc > PIX2 - 32'd1 ? PIX2 - 32'd1 : Sin_inc;
        sum      = {1'b0, Phase} + {1'b0, inc_eff};
        wrap_c   = sum >= {1'b0, PIX2};
        sync_now = sync_flag | Phase_sync;
        q_c      = Phase < HALFPI ? 2'd0 : Phase < PI ? 2'd1 : Phase < PI + HALFPI ? 2'd2 : 2'd3;
        base_c   = q_c == 2'd0 ? 32'd0 : q_c == 2'd1 ? HALFPI : q_c == 2'd2 ? PI : PI + HALFPI;
        prod     = 34'(off2) * 34'(INV_HALFPI);
        scaled   = prod >> (32 - LUT_AW);
        a_sat    = scaled > 34'(2**LUT_AW - 1) ? '1 : scaled[LUT_AW-1:0];
    end

    always_ff @(posedge Sys_clk) begin
        if (Osc_rst) begin
            Phase      <= '0;
            Wrap       <= 1'b0;
            sync_flag  <= 1'b0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
            v4         <= 1'b0;
            q2         <= '0;
            q3         <= '0;
            q4         <= '0;
            off2       <= '0;
            addr3      <= '0;
            Sample     <= '0;
            Sample_vld <= 1'b0;
        end else if (Osc_ce) begin
            if (Upd_tick)
                Phase <= sync_now ? '0 : wrap_c ? 32'(sum - {1'b0, PIX2}) : sum[31:0];
            Wrap       <= Upd_tick && !sync_now && wrap_c;
            sync_flag  <= Upd_tick ? 1'b0 : sync_flag | Phase_sync;
            v1         <= Upd_tick;
            v2         <= v1;
            v3         <= v2;
            v4         <= v3;
            q2         <= q_c;
            off2       <= 18'(Phase - base_c);
            q3         <= q2;
            addr3      <= q2[0] ? ~a_sat : a_sat;
            q4         <= q3;
            if (v4)
                Sample <= q4[1] ? 16'(-rom_q) : rom_q;
            Sample_vld <= v4;
        end
    end

    sine_quarter_rom #(
        .LUT_AW(LUT_AW)
    ) u_rom (
        .clk (Sys_clk),
        .rst (Osc_rst),
        .ce  (Osc_ce),
        .addr(addr3),
        .data(rom_q)
    );
endmodule

// File: tb/tb_sinusoid_phase_accumulator.sv
// tb_sinusoid_phase_accumulator: randomized scoreboard bench against an arithmetic phase/sine model.
module tb_sinusoid_phase_accumulator;
    import osc_pkg::*;

    logic               Sys_clk = 1'b0;
    logic               Osc_rst = 1'b1;
    logic               Osc_ce = 1'b1;
    logic               Upd_tick = 1'b0;
    logic               Phase_sync = 1'b0;
    logic [31:0]        Sin_inc = '0;
    logic [31:0]        Phase;
    logic               Wrap;
    logic signed [15:0] Sample;
    logic               Sample_vld;

    always #5 Sys_clk = ~Sys_clk;

    sinusoid_phase_accumulator #(.LUT_AW(8)) dut (
        .Sys_clk   (Sys_clk),
        .Osc_rst   (Osc_rst),
        .Osc_ce    (Osc_ce),
        .Upd_tick  (Upd_tick),
        .Phase_sync(Phase_sync),
        .Sin_inc   (Sin_inc),
        .Phase     (Phase),
        .Wrap      (Wrap),
        .Sample    (Sample),
        .Sample_vld(Sample_vld)
    );

    typedef struct { longint val; longint due; } exp_t;
    exp_t   sb[$];
    int     n_cmp = 0;
    int     n_bad = 0;
    int     dut_wraps = 0;
    longint ecnt = 0;
    bit     edge_act = 0;
    longint m_phase = 0;
    bit     m_wrap = 0;
    bit     m_flag = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic chk_tol(input string nm, input longint act, input longint exp, input longint tol);
        n_cmp++;
        if (act > exp + tol || act < exp - tol) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d +/- %0d", nm, act, exp, tol);
        end
    endtask

    // Ideal sample for a phase: fold into a quarter, quantise to a table bin, take the bin-centre sine.
    function automatic longint ideal_sample(input longint p);
        longint bnd[4];
        longint off, a, r;
        int q;
        bnd = '{0, HALFPI, PI, PI + HALFPI};
        q = 0;
        for (int k = 1; k < 4; k++)
            if (p >= bnd[k]) q = k;
        off = p - bnd[q];
        a = (off * 'hA2FA) >> 24;
        if (a > 255) a = 255;
        if (q % 2 == 1) a = 255 - a;
        r = longint'(int'(32767.0 * $sin((real'(a) + 0.5) * 3.141592653589793 / 512.0)));
        return q >= 2 ? -r : r;
    endfunction

    always @(posedge Sys_clk) begin
        longint inc;
        edge_act = Osc_rst || Osc_ce;
        if (Osc_rst) begin
            m_phase = 0;
            m_wrap = 0;
            m_flag = 0;
            sb.delete();
        end else if (Osc_ce) begin
            ecnt++;
            m_wrap = 0;
            if (Upd_tick) begin
                if (m_flag || Phase_sync) m_phase = 0;
                else begin
                    inc = longint'(Sin_inc);
                    if (inc > longint'(PIX2) - 1) inc = longint'(PIX2) - 1;
                    m_phase = m_phase + inc;
                    if (m_phase >= longint'(PIX2)) begin
                        m_phase = m_phase - longint'(PIX2);
                        m_wrap = 1;
                    end
                end
                m_flag = 0;
                sb.push_back('{ideal_sample(m_phase), ecnt + 4});
            end else if (Phase_sync) m_flag = 1;
        end
    end

    always @(negedge Sys_clk) begin
        exp_t e;
        chk("phase", longint'(Phase), m_phase);
        chk("wrap", longint'(Wrap), longint'(m_wrap));
        if (edge_act && Wrap) dut_wraps++;
        if (edge_act && Sample_vld) begin
            if (sb.size() == 0) chk("unexpected_strobe", 1, 0);
            else begin
                e = sb.pop_front();
                chk_tol("sample", longint'(Sample), e.val, 2);
                chk("sample_latency", ecnt, e.due);
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge Sys_clk);
    endtask

    task automatic tick(input logic [31:0] inc, input bit sync);
        Sin_inc = inc;
        Phase_sync = sync;
        Upd_tick = 1'b1;
        @(negedge Sys_clk);
        Upd_tick = 1'b0;
        Phase_sync = 1'b0;
        Sin_inc = $urandom;
    endtask

    task automatic pulse_reset();
        Osc_rst = 1'b1;
        @(negedge Sys_clk);
        Osc_rst = 1'b0;
    endtask

    initial begin
        idle(3);
        chk("rst_phase", longint'(Phase), 0);
        chk("rst_wrap", longint'(Wrap), 0);
        chk("rst_sample", longint'(Sample), 0);
        chk("rst_vld", longint'(Sample_vld), 0);
        Osc_rst = 1'b0;
        idle(6);
        chk("no_strobe_before_tick", longint'(Sample_vld), 0);

        dut_wraps = 0;
        repeat (1000) tick(32'h19C, 0);
        idle(1);
        chk("khz_final_phase", longint'(Phase), 'hE2);
        chk("khz_wrap_count", dut_wraps, 1);
        idle(6);

        pulse_reset();
        repeat (8) tick(HALFPI, 0);
        idle(6);

        pulse_reset();
        dut_wraps = 0;
        repeat (100) tick(32'hFFFF_FFFF, 0);
        idle(1);
        chk("maxinc_wrap_count", dut_wraps, 99);
        idle(6);

        repeat (10) begin
            tick($urandom, 0);
            idle($urandom_range(0, 2));
        end
        tick(32'h0, 0);
        Phase_sync = 1'b1;
        @(negedge Sys_clk);
        Phase_sync = 1'b0;
        idle(1);
        tick($urandom, 0);
        chk("sync_phase", longint'(Phase), 0);
        chk("sync_wrap", longint'(Wrap), 0);
        tick($urandom, 0);
        tick($urandom, 1);
        chk("sync_coincident_phase", longint'(Phase), 0);
        idle(6);

        repeat (3) tick($urandom_range(0, 'h20000), 0);
        Osc_ce = 1'b0;
        idle(7);
        Osc_ce = 1'b1;
        idle(6);
        repeat (3) tick($urandom_range(0, 'h20000), 0);
        idle(1);
        pulse_reset();
        chk("mid_rst_vld", longint'(Sample_vld), 0);
        idle(8);

        for (int i = 0; i < 600; i++) begin
            Osc_ce = $urandom_range(0, 7) != 0;
            Upd_tick = $urandom_range(0, 2) == 0;
            Phase_sync = $urandom_range(0, 15) == 0;
            Sin_inc = $urandom_range(0, 3) == 0 ? $urandom : $urandom_range(0, 'h20000);
            Osc_rst = $urandom_range(0, 149) == 0;
            @(negedge Sys_clk);
        end
        Osc_ce = 1'b1;
        Upd_tick = 1'b0;
        Phase_sync = 1'b0;
        Osc_rst = 1'b0;
        for (int i = 0; i < 50 && sb.size() > 0; i++) @(negedge Sys_clk);
        chk("drain_pending", sb.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
